aes_sub_word: RTL and testbench

AES SubWord stage: applies the AES forward S-box independently to each of the four bytes of a 32-bit word and presents the result registered, one clock after a valid input. Used by the AES-128 encryption key-expansion path (RotWord → SubWord → Rcon XOR) and reusable for column-wise SubBytes. Optionally also provides the inverse S-box for the decryption datapath.

---
 rtl/aes_pkg.sv | 82 ++++++++
 rtl/aes_sub_word_if.sv | 34 +++
 rtl/aes_sbox.sv | 23 ++
 rtl/aes_sub_word.sv | 48 ++++
 tb/tb_aes_sub_word.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions: byte/word types, FIPS-197 S-box tables, reset value.
// Optional feature macro: AES_SUB_WORD_INV_EN (adds the inverse S-box table).
package aes_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_word_t;

    localparam aes_word_t WordRstVal = 32'h0000_0000;

    localparam aes_byte_t Sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef AES_SUB_WORD_INV_EN
    localparam aes_byte_t InvSbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/aes_sub_word_if.sv
// Word-substitution bus: input word/valid (plus inverse select) and registered result.
// Optional feature macro: AES_SUB_WORD_INV_EN (adds i_inv).
interface aes_sub_word_if;
    import aes_pkg::*;

`ifdef AES_SUB_WORD_INV_EN
    logic      i_inv;
`endif
    logic      i_valid;
    aes_word_t i_word;
    logic      o_valid;
    aes_word_t o_word;

    modport master (
`ifdef AES_SUB_WORD_INV_EN
        output i_inv,
`endif
        output i_valid,
        output i_word,
        input  o_valid,
        input  o_word
    );

    modport slave (
`ifdef AES_SUB_WORD_INV_EN
        input  i_inv,
`endif
        input  i_valid,
        input  i_word,
        output o_valid,
        output o_word
    );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, purely combinational.
// Optional feature macro: AES_SUB_WORD_INV_EN (adds inv_i and the inverse table).
module aes_sbox
    import aes_pkg::*;
(
`ifdef AES_SUB_WORD_INV_EN
    input  logic      inv_i,
`endif
    input  aes_byte_t data_i,
    output aes_byte_t data_o
);

    // Table lookup; inverse table overrides the forward result when selected
    always_comb begin
        data_o = Sbox[data_i];
`ifdef AES_SUB_WORD_INV_EN
        if (inv_i) begin
            data_o = InvSbox[data_i];
        end
`endif
    end

endmodule

// File: rtl/aes_sub_word.sv
// AES SubWord: four independent byte lookups followed by one output register.
// Optional feature macro: AES_SUB_WORD_INV_EN (per-word inverse S-box select).
module aes_sub_word
    import aes_pkg::*;
(
    input logic           i_clk,
    input logic           i_rst,
    aes_sub_word_if.slave bus
);

    aes_word_t sub_word;
    aes_word_t word_d, word_q;
    logic      valid_d, valid_q;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        aes_sbox u_sbox (
`ifdef AES_SUB_WORD_INV_EN
            .inv_i  (bus.i_inv),
`endif
            .data_i (bus.i_word[8*k +: 8]),
            .data_o (sub_word[8*k +: 8])
        );
    end

    // Next state: capture on valid, otherwise hold the last result
    always_comb begin
        valid_d = bus.i_valid;
        word_d  = word_q;
        if (bus.i_valid) begin
            word_d = sub_word;
        end
    end

    // Output register; synchronous reset wins over a simultaneous valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            word_q  <= WordRstVal;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_word  = word_q;

endmodule

// File: tb/tb_aes_sub_word.sv
// Bench for aes_sub_word: S-box reference built from GF(2^8) inversion plus affine map.
// Optional feature macro: AES_SUB_WORD_INV_EN (enables inverse-table checks).
module tb_aes_sub_word;

    logic clk;
    logic rst;

    aes_sub_word_if bus ();

    aes_sub_word dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  ref_sbox [256];
    logic [7:0]  ref_inv  [256];
    logic [31:0] exp_word;
    logic        exp_valid;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = inv ? ref_inv[w[8*k +: 8]] : ref_sbox[w[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model at the edge, then compare
    task automatic step(input logic r, input logic v, input logic [31:0] w, input logic inv);
        rst         = r;
        bus.i_valid = v;
        bus.i_word  = w;
`ifdef AES_SUB_WORD_INV_EN
        bus.i_inv   = inv;
`endif
        @(posedge clk);
        if (r) begin
            exp_word  = 32'h0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) exp_word = ref_word(w, inv);
        end
        #1;
        check("valid", {31'b0, bus.o_valid}, {31'b0, exp_valid});
        check("word", bus.o_word, exp_word);
    endtask

    initial begin
        logic [31:0] w;
        logic        v;
        logic        inv;
        logic        r;

        for (int x = 0; x < 256; x++) ref_sbox[x] = sbox_calc(x[7:0]);
        for (int x = 0; x < 256; x++) ref_inv[ref_sbox[x]] = x[7:0];

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_word  = 32'h0;
`ifdef AES_SUB_WORD_INV_EN
        bus.i_inv   = 1'b0;
`endif
        @(negedge clk);

        // Reset dominates a valid input
        step(1'b1, 1'b1, 32'hffff_ffff, 1'b0);
        step(1'b1, 1'b1, 32'hffff_ffff, 1'b0);
        check("rst_word", bus.o_word, 32'h0000_0000);

        // Directed forward vectors, first captured on the first edge out of reset
        step(1'b0, 1'b1, 32'hcf4f_3c09, 1'b0);
        check("fwd_cf4f3c09", bus.o_word, 32'h8a84_eb01);
        step(1'b0, 1'b1, 32'h2c6b_7b52, 1'b0);
        check("fwd_2c6b7b52", bus.o_word, 32'h717f_2100);
        step(1'b0, 1'b1, 32'h5d5b_9ab7, 1'b0);
        check("fwd_5d5b9ab7", bus.o_word, 32'h4c39_b8a9);
        step(1'b0, 1'b1, 32'h0000_0000, 1'b0);
        check("fwd_zero", bus.o_word, 32'h6363_6363);
        step(1'b0, 1'b1, 32'hffff_ffff, 1'b0);
        check("fwd_ones", bus.o_word, 32'h1616_1616);
        step(1'b0, 1'b1, 32'h0102_0304, 1'b0);
        check("fwd_01020304", bus.o_word, 32'h7c77_7bf2);

        // Hold with valid low while the input word keeps changing
        step(1'b0, 1'b1, 32'hcf4f_3c09, 1'b0);
        step(1'b0, 1'b0, 32'h1234_5678, 1'b0);
        check("hold_1", bus.o_word, 32'h8a84_eb01);
        step(1'b0, 1'b0, 32'hdead_beef, 1'b0);
        check("hold_2", bus.o_word, 32'h8a84_eb01);

        // Reset mid-stream discards the word presented with it
        step(1'b0, 1'b1, 32'h0102_0304, 1'b0);
        step(1'b1, 1'b1, 32'h5d5b_9ab7, 1'b0);
        check("midrst", bus.o_word, 32'h0000_0000);

`ifdef AES_SUB_WORD_INV_EN
        step(1'b0, 1'b1, 32'h8a84_eb01, 1'b1);
        check("inv_8a84eb01", bus.o_word, 32'hcf4f_3c09);
        step(1'b0, 1'b1, 32'h6363_6363, 1'b1);
        check("inv_63636363", bus.o_word, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, $urandom, i[0]);
        end
`endif

        // Sweep every byte value replicated across all lanes
        for (int b = 0; b < 256; b++) begin
            step(1'b0, 1'b1, {4{b[7:0]}}, 1'b0);
`ifdef AES_SUB_WORD_INV_EN
            step(1'b0, 1'b1, {4{ref_sbox[b]}}, 1'b1);
            check("roundtrip", bus.o_word, {4{b[7:0]}});
`endif
        end

        // Random traffic with sparse valids and occasional resets
        for (int i = 0; i < 300; i++) begin
            w   = $urandom;
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 31) == 0);
`ifdef AES_SUB_WORD_INV_EN
            inv = 1'($urandom_range(0, 1));
`else
            inv = 1'b0;
`endif
            step(r, v, w, inv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
